// File: rtl/det_pkg.sv
// Shared types and constants for the sequenced 2x2/3x3 determinant controller.
package det_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OUT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic MODE_2X2 = 1'b0;
  localparam logic MODE_3X3 = 1'b1;

  // Bit j set means cofactor j is subtracted (+,-,+ across row 0).
  localparam logic [2:0] COF_SUB = 3'b010;

endpackage

// File: rtl/minor2.sv
// Combinational 2x2 minor a*d - b*c at full precision (2*DATA_W+1 bits).
module minor2 #(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [2*DATA_W:0] m
);

  localparam int MW = 2 * DATA_W + 1;

  logic signed [MW-1:0] ax, bx, cx, dx;

  assign ax = MW'(a);
  assign bx = MW'(b);
  assign cx = MW'(c);
  assign dx = MW'(d);
  assign m  = (ax * dx) - (bx * cx);

endmodule

// File: rtl/det_seq_ctrl.sv
// Determinant sequencer: 2x2 in one step, 3x3 by first-row cofactor expansion
// using a single time-shared minor2 unit and a full-precision accumulator.
module det_seq_ctrl
  import det_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int ACC_W  = 3 * DATA_W + 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [9*DATA_W-1:0] mat,
  output logic                busy,
  output logic                done,
  output logic [OUT_W-1:0]    det,
  output logic [ACC_W-1:0]    det_full,
  output logic                ovf
);

  // Handshake: start is a request honoured only while the FSM is in IDLE
  // (mode/mat sampled on that same edge); there is no backpressure. done is a
  // one-cycle pulse with det/det_full/ovf valid alongside it, and they hold
  // until the next completion or reset. start outside IDLE is dropped.

  localparam int MW = 2 * DATA_W + 1;

  state_t                     state, state_nxt;
  logic [1:0]                 idx;
  logic                       mode_r;
  logic [9*DATA_W-1:0]        mat_r;
  logic signed [ACC_W-1:0]    acc, acc_nxt, term;
  logic signed [DATA_W-1:0]   ma, mb, mc, md, coef;
  logic signed [MW-1:0]       minor;
  logic [ACC_W-OUT_W:0]       upper;
  logic                       capture, ovf_calc;

  function automatic logic [DATA_W-1:0] elem(input logic [9*DATA_W-1:0] m,
                                             input int r, input int c);
    return m[9*DATA_W-1-DATA_W*(3*r+c) -: DATA_W];
  endfunction

  // Operand steering: idx picks the column excluded from rows 1 and 2.
  always_comb begin
    ma   = elem(mat_r, 1, 1);
    mb   = elem(mat_r, 1, 2);
    mc   = elem(mat_r, 2, 1);
    md   = elem(mat_r, 2, 2);
    coef = elem(mat_r, 0, 0);
    if (mode_r == MODE_2X2) begin
      ma   = elem(mat_r, 0, 0);
      mb   = elem(mat_r, 0, 1);
      mc   = elem(mat_r, 1, 0);
      md   = elem(mat_r, 1, 1);
      coef = '0;
    end else begin
      case (idx)
        2'd1: begin
          ma   = elem(mat_r, 1, 0);
          mb   = elem(mat_r, 1, 2);
          mc   = elem(mat_r, 2, 0);
          md   = elem(mat_r, 2, 2);
          coef = elem(mat_r, 0, 1);
        end
        2'd2: begin
          ma   = elem(mat_r, 1, 0);
          mb   = elem(mat_r, 1, 1);
          mc   = elem(mat_r, 2, 0);
          md   = elem(mat_r, 2, 1);
          coef = elem(mat_r, 0, 2);
        end
        default: ;
      endcase
    end
  end

  minor2 #(.DATA_W(DATA_W)) u_minor (
    .a (ma),
    .b (mb),
    .c (mc),
    .d (md),
    .m (minor)
  );

  always_comb begin
    term    = ACC_W'(coef) * ACC_W'(minor);
    acc_nxt = acc + term;
    if (mode_r == MODE_2X2)
      acc_nxt = ACC_W'(minor);
    else if (COF_SUB[idx])
      acc_nxt = acc - term;
  end

  // Result fits OUT_W only when all bits from OUT_W-1 upward agree.
  assign upper    = acc[ACC_W-1:OUT_W-1];
  assign ovf_calc = !((&upper) || (~|upper));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (mode_r == MODE_2X2 || idx == 2'd2)
          state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      mode_r   <= MODE_2X2;
      mat_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      det      <= '0;
      det_full <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state != IDLE);
      done  <= (state == FIN);
      if (capture) begin
        mat_r  <= mat;
        mode_r <= mode;
        acc    <= '0;
        idx    <= '0;
      end
      if (state == CALC) begin
        acc <= acc_nxt;
        idx <= idx + 2'd1;
      end
      if (state == FIN) begin
        det_full <= acc;
        det      <= acc[OUT_W-1:0];
        ovf      <= ovf_calc;
      end
    end
  end

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Directed bench for det_seq_ctrl: latency, pulse shape, arithmetic, overflow,
// ignored starts and mid-operation reset.
module tb_det_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 8;
  localparam int ACC_W  = 27;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic [9*DATA_W-1:0] mat;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  det;
  logic [ACC_W-1:0]  det_full;
  logic              ovf;

  int n_cmp = 0;
  int n_err = 0;

  det_seq_ctrl #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .mat      (mat),
    .busy     (busy),
    .done     (done),
    .det      (det),
    .det_full (det_full),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_full(input string tag, input logic [ACC_W-1:0] obs, input int exp);
    logic [ACC_W-1:0] e;
    e = exp[ACC_W-1:0];
    chk(tag, {37'b0, obs}, {37'b0, e});
  endtask

  function automatic logic [71:0] m3(input int a00, input int a01, input int a02,
                                     input int a10, input int a11, input int a12,
                                     input int a20, input int a21, input int a22);
    return {a00[7:0], a01[7:0], a02[7:0], a10[7:0], a11[7:0], a12[7:0],
            a20[7:0], a21[7:0], a22[7:0]};
  endfunction

  task automatic do_op(input string tag, input logic md, input logic [71:0] m,
                       input int exp_full, input logic exp_ovf);
    int lat;
    logic [31:0] ef;
    lat = md ? 4 : 2;
    ef  = exp_full;
    mode  = md;
    mat   = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = ~md;
    mat   = 72'({$urandom(), $urandom(), $urandom()});
    for (int k = 1; k < lat; k++) begin
      tick();
      chk({tag, "_busy_mid"}, busy, 1);
      chk({tag, "_done_mid"}, done, 0);
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_fin"}, busy, 1);
    chk({tag, "_det"}, det, ef[7:0]);
    chk_full({tag, "_det_full"}, det_full, exp_full);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    tick();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_busy_clr"}, busy, 0);
    chk({tag, "_det_hold"}, det, ef[7:0]);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    mat   = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det", det, 0);
    chk_full("rst_det_full", det_full, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    tick();

    // 2x2 with junk in row 2 / column 2 that must be ignored.
    do_op("m2_basic", 1'b0, m3(2, 3, 9, 4, 2, 9, 9, 9, 9), -8, 1'b0);
    do_op("m3_diag", 1'b1, m3(2, 0, 0, 0, 3, 0, 0, 0, 4), 24, 1'b0);

    // Accumulator walk: +1*2, -2*(-2), +3*(-3).
    mode  = 1'b1;
    mat   = m3(1, 2, 3, 4, 5, 6, 7, 8, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_full("acc_j0", dut.acc, 2);
    tick();
    chk_full("acc_j1", dut.acc, 6);
    tick();
    chk_full("acc_j2", dut.acc, -3);
    tick();
    chk("walk_done", done, 1);
    chk("walk_det", det, 8'hFD);
    chk_full("walk_det_full", det_full, -3);
    tick();

    do_op("m3_ovf", 1'b1, m3(127, 0, 0, 0, 127, 0, 0, 0, 127), 2048383, 1'b1);
    do_op("m3_sing", 1'b1, m3(1, 2, 3, 2, 4, 6, 1, 1, 1), 0, 1'b0);
    do_op("m2_neg", 1'b0, m3(-3, 5, 0, 7, 2, 0, 0, 0, 0), -41, 1'b0);
    do_op("m2_ovf", 1'b0, m3(100, -100, 0, 100, 100, 0, 0, 0, 0), 20000, 1'b1);
    do_op("m3_min", 1'b1, m3(-128, 0, 0, 0, -128, 0, 0, 0, -128), -2097152, 1'b1);

    // Starts during an operation are dropped; restart right after done.
    mode  = 1'b1;
    mat   = m3(2, 0, 0, 0, 3, 0, 0, 0, 4);
    start = 1'b1;
    tick();
    mode = 1'b0;
    mat  = m3(5, 1, 0, 1, 5, 0, 0, 0, 0);
    tick();
    tick();
    start = 1'b0;
    tick();
    chk("ign_done_t3", done, 0);
    tick();
    chk("ign_done_t4", done, 1);
    chk("ign_det", det, 8'h18);
    mode  = 1'b1;
    mat   = m3(1, 2, 3, 4, 5, 6, 7, 8, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_done_clr", done, 0);
    tick();
    chk("b2b_busy", busy, 1);
    tick();
    tick();
    tick();
    chk("b2b_done", done, 1);
    chk("b2b_det", det, 8'hFD);
    tick();

    // Reset in the middle of a 3x3 operation.
    mode  = 1'b1;
    mat   = m3(2, 0, 0, 0, 3, 0, 0, 0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_det", det, 0);
    chk_full("mrst_det_full", det_full, 0);
    chk("mrst_ovf", ovf, 0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mrst_no_done", done, 0);
      chk("mrst_idle", busy, 0);
    end
    do_op("post_rst", 1'b1, m3(1, 2, 3, 4, 5, 6, 7, 8, 10), -3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
